adpcma_fetch: RTL and testbench

Upstream ROM-fetch engine for the ADPCM-A sample path. It streams bytes from V-ROM through the multiplexed sample-ROM bus (SDRAD/SDRA_L/SDRA_U, SDRMPX, nSDROE), which the PCM address demultiplexer latches and decodes. A start/end byte range is loaded, bytes are fetched sequentially into a 2-entry FIFO, and they are delivered on a valid/ready stream to the ADPCM decoder.

---
 rtl/adpcma_fetch.sv | 200 ++++++++++++++++++++
 tb/tb_adpcma_fetch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/adpcma_fetch.sv
// rtl/adpcma_fetch.sv - ADPCM-A V-ROM fetch engine: multiplexed sample-ROM bus reads into a 2-entry FIFO
module adpcma_fetch #(
    parameter int RD_CYCLES = 3
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        START,
    input  logic [23:0] START_ADDR,
    input  logic [23:0] END_ADDR,
    input  logic        STOP,
    output logic [7:0]  DOUT,
    output logic        DOUT_VALID,
    input  logic        DOUT_READY,
    output logic        BUSY,
    output logic        DONE,
    inout  wire  [7:0]  SDRAD,
    output logic [1:0]  SDRA_L,
    output logic [3:0]  SDRA_U,
    output logic        SDRMPX,
    output logic        nSDROE
);

    typedef enum logic [2:0] {
        S_IDLE, S_LO, S_LATL, S_HI, S_LATH, S_TA, S_RD, S_WAITF
    } state_t;

    localparam logic [3:0] RD_LAST = 4'(RD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic [23:0] end_q, end_d;
    logic [3:0]  rd_cnt_q, rd_cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        abort_q, abort_d;
    logic [7:0]  head_q, head_d, tail_q, tail_d;
    logic        head_v_q, head_v_d, tail_v_q, tail_v_d;

    logic        pop, rd_last, abort_req, capture, flush;
    logic [1:0]  occ_q, occ_d;
    logic        drive, hi_phase;
    logic [7:0]  ad_out;

    assign pop       = head_v_q & DOUT_READY;
    assign rd_last   = (state_q == S_RD) && (rd_cnt_q == RD_LAST);
    assign abort_req = abort_q | (STOP & busy_q);
    // An aborted bus cycle still completes on the pins, but its byte is dropped.
    assign capture   = rd_last & ~abort_req;
    assign occ_q     = {1'b0, head_v_q} + {1'b0, tail_v_q};
    assign occ_d     = occ_q - {1'b0, pop} + {1'b0, capture};

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        end_d    = end_q;
        rd_cnt_d = rd_cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        abort_d  = abort_req;
        flush    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!busy_q) begin
                    abort_d = 1'b0;
                    if (START) begin
                        addr_d  = START_ADDR;
                        end_d   = END_ADDR;
                        busy_d  = 1'b1;
                        state_d = S_LO;
                    end
                end else if (abort_q) begin
                    busy_d  = 1'b0;
                    abort_d = 1'b0;
                end else if (abort_req) begin
                    flush = 1'b1;
                end else if (occ_d == 2'd0) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            S_LO:   state_d = S_LATL;
            S_LATL: state_d = S_HI;
            S_HI:   state_d = S_LATH;
            S_LATH: state_d = S_TA;
            S_TA: begin
                rd_cnt_d = 4'd0;
                state_d  = S_RD;
            end
            S_RD: begin
                if (!rd_last) begin
                    rd_cnt_d = rd_cnt_q + 4'd1;
                end else if (abort_req) begin
                    flush   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    addr_d = addr_q + 24'd1;
                    if (addr_q == end_q)     state_d = S_IDLE;
                    else if (occ_d < 2'd2)   state_d = S_LO;
                    else                     state_d = S_WAITF;
                end
            end
            S_WAITF: begin
                if (abort_req) begin
                    flush   = 1'b1;
                    state_d = S_IDLE;
                end else if (occ_d < 2'd2) begin
                    state_d = S_LO;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Two-entry FIFO whose head register is DOUT itself.
    always_comb begin
        head_d   = head_q;
        head_v_d = head_v_q;
        tail_d   = tail_q;
        tail_v_d = tail_v_q;
        if (pop) begin
            if (tail_v_q) begin
                head_d   = tail_q;
                tail_v_d = 1'b0;
            end else begin
                head_v_d = 1'b0;
            end
        end
        if (capture) begin
            if (!head_v_d) begin
                head_d   = SDRAD;
                head_v_d = 1'b1;
            end else begin
                tail_d   = SDRAD;
                tail_v_d = 1'b1;
            end
        end
        if (flush) begin
            head_v_d = 1'b0;
            tail_v_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= S_IDLE;
            addr_q   <= 24'd0;
            end_q    <= 24'd0;
            rd_cnt_q <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
            head_q   <= 8'd0;
            head_v_q <= 1'b0;
            tail_q   <= 8'd0;
            tail_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            end_q    <= end_d;
            rd_cnt_q <= rd_cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
            head_q   <= head_d;
            head_v_q <= head_v_d;
            tail_q   <= tail_d;
            tail_v_q <= tail_v_d;
        end
    end

    // Bus pins decode straight from state, so async reset releases them at once.
    assign drive    = (state_q == S_LO) || (state_q == S_LATL) || (state_q == S_HI) || (state_q == S_LATH);
    assign hi_phase = (state_q == S_HI) || (state_q == S_LATH);
    assign ad_out   = hi_phase ? addr_q[17:10] : addr_q[7:0];
    assign SDRAD    = drive ? ad_out : 8'bz;

    always_comb begin
        SDRA_L = 2'd0;
        SDRA_U = 4'd0;
        case (state_q)
            S_LO, S_LATL: begin
                SDRA_L = addr_q[9:8];
                SDRA_U = addr_q[23:20];
            end
            S_HI, S_LATH, S_TA, S_RD: begin
                SDRA_L = addr_q[19:18];
                SDRA_U = addr_q[23:20];
            end
            default: ;
        endcase
    end

    assign SDRMPX     = (state_q == S_LATL) || (state_q == S_HI);
    assign nSDROE     = (state_q != S_RD);
    assign DOUT       = head_q;
    assign DOUT_VALID = head_v_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;

endmodule

// File: tb/tb_adpcma_fetch.sv
// tb/tb_adpcma_fetch.sv - directed vector bench for adpcma_fetch with a demux/ROM model on the bus
module tb_adpcma_fetch;

    localparam int RDC     = 3;
    localparam int BUS_LEN = 5 + RDC;

    logic        CLK = 1'b0;
    logic        nRESET = 1'b0;
    logic        START = 1'b0;
    logic        STOP = 1'b0;
    logic        DOUT_READY = 1'b0;
    logic [23:0] START_ADDR = 24'd0;
    logic [23:0] END_ADDR = 24'd0;
    logic [7:0]  DOUT;
    logic        DOUT_VALID, BUSY, DONE, SDRMPX, nSDROE;
    logic [1:0]  SDRA_L;
    logic [3:0]  SDRA_U;
    wire  [7:0]  SDRAD;

    adpcma_fetch #(.RD_CYCLES(RDC)) dut (
        .CLK(CLK), .nRESET(nRESET), .START(START), .START_ADDR(START_ADDR),
        .END_ADDR(END_ADDR), .STOP(STOP), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID),
        .DOUT_READY(DOUT_READY), .BUSY(BUSY), .DONE(DONE), .SDRAD(SDRAD),
        .SDRA_L(SDRA_L), .SDRA_U(SDRA_U), .SDRMPX(SDRMPX), .nSDROE(nSDROE)
    );

    initial forever #5 CLK = ~CLK;

    function automatic logic [7:0] rom_f(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hD5;
    endfunction

    logic [23:0] lat_addr = 24'd0;
    logic [9:0]  lo10 = 10'd0;
    logic        mpx_prev = 1'b0;
    assign SDRAD = (!nSDROE) ? rom_f(lat_addr) : 8'bz;

    int n_chk = 0, n_pass = 0;
    int cyc_n = 0, oe_run = 0, last_run = 0, bus_cycles = 0, done_cnt = 0, done_t = 0, cont_err = 0;
    logic [23:0] addr_log[$];
    logic [7:0]  pop_log[$];
    int          pop_t[$];

    typedef struct {
        logic [23:0] sa;
        logic [23:0] ea;
        int          n;
        bit          rmode;
        bit          rate;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic sample();
        cyc_n++;
        if (SDRMPX && !mpx_prev) lo10 = {SDRA_L, SDRAD};
        if (!SDRMPX && mpx_prev) begin
            lat_addr = {SDRA_U, SDRA_L, SDRAD, lo10};
            addr_log.push_back(lat_addr);
        end
        mpx_prev = SDRMPX;
        if (!nSDROE) begin
            oe_run++;
            if (SDRAD !== rom_f(lat_addr)) cont_err++;
        end else if (oe_run > 0) begin
            last_run = oe_run;
            oe_run = 0;
            bus_cycles++;
        end
        if (DOUT_VALID && DOUT_READY) begin
            pop_log.push_back(DOUT);
            pop_t.push_back(cyc_n);
        end
        if (DONE) begin
            done_cnt++;
            done_t = cyc_n;
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        sample();
        @(posedge CLK);
        #2;
    endtask

    task automatic clear_logs();
        addr_log.delete();
        pop_log.delete();
        pop_t.delete();
        oe_run = 0; last_run = 0; bus_cycles = 0; done_cnt = 0; done_t = 0; cont_err = 0;
    endtask

    task automatic pulse_start(input logic [23:0] sa, input logic [23:0] ea);
        START_ADDR = sa;
        END_ADDR   = ea;
        START      = 1'b1;
        tick();
        START      = 1'b0;
    endtask

    task automatic check_stream(input string tag, input logic [23:0] sa, input int n);
        int bad_a = 0, bad_d = 0;
        check({tag, " addr_count"}, addr_log.size(), n);
        check({tag, " byte_count"}, pop_log.size(), n);
        for (int i = 0; i < n; i++) begin
            logic [23:0] e = sa + 24'(i);
            if (i >= addr_log.size() || addr_log[i] != e) bad_a++;
            if (i >= pop_log.size() || pop_log[i] != rom_f(e)) bad_d++;
        end
        check({tag, " addr_seq_errors"}, bad_a, 0);
        check({tag, " data_seq_errors"}, bad_d, 0);
        check({tag, " contention"}, cont_err, 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        clear_logs();
        DOUT_READY = 1'b1;
        pulse_start(v.sa, v.ea);
        for (int k = 0; k < 600 && done_cnt == 0; k++) begin
            DOUT_READY = v.rmode ? cyc_n[0] : 1'b1;
            tick();
        end
        if (done_cnt == 0) check({tag, " done_timeout"}, 0, 1);
        for (int k = 0; k < 4; k++) tick();
        check_stream(tag, v.sa, v.n);
        check({tag, " done_count"}, done_cnt, 1);
        check({tag, " busy_after"}, BUSY, 0);
        check({tag, " bus_cycles"}, bus_cycles, v.n);
        check({tag, " oe_low_cycles"}, last_run, RDC);
        if (pop_t.size() > 0) check({tag, " done_after_pop"}, done_t, pop_t[pop_t.size()-1] + 1);
        if (v.rate) begin
            int bad_r = 0;
            for (int i = 1; i < pop_t.size(); i++)
                if (pop_t[i] - pop_t[i-1] != BUS_LEN) bad_r++;
            check({tag, " rate_errors"}, bad_r, 0);
        end
    endtask

    initial begin
        vecs[0] = '{sa: 24'h123456, ea: 24'h123456, n: 1, rmode: 1'b0, rate: 1'b0};
        vecs[1] = '{sa: 24'h000100, ea: 24'h000107, n: 8, rmode: 1'b0, rate: 1'b1};
        vecs[2] = '{sa: 24'hFFFFFE, ea: 24'h000001, n: 4, rmode: 1'b0, rate: 1'b0};
        vecs[3] = '{sa: 24'hABCDEF, ea: 24'hABCDF3, n: 5, rmode: 1'b1, rate: 1'b0};

        tick();
        tick();
        check("rst SDRMPX", SDRMPX, 0);
        check("rst nSDROE", nSDROE, 1);
        check("rst SDRA_L", SDRA_L, 0);
        check("rst SDRA_U", SDRA_U, 0);
        check("rst DOUT", DOUT, 0);
        check("rst DOUT_VALID", DOUT_VALID, 0);
        check("rst BUSY", BUSY, 0);
        check("rst DONE", DONE, 0);
        nRESET = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            if (i == 0) begin
                check("single lo10", lat_addr[9:0], 10'h056);
                check("single hi10", lat_addr[19:10], 10'h08D);
                check("single SDRA_U", lat_addr[23:20], 4'h1);
                check("single DOUT", pop_log.size() > 0 ? pop_log[0] : 8'h00, 8'hA5);
            end
        end

        // Backpressure: consumer stalled, fetch must stop after two bytes.
        clear_logs();
        DOUT_READY = 1'b0;
        pulse_start(24'h000200, 24'h000205);
        for (int k = 0; k < 40; k++) tick();
        check("bp bus_cycles_stalled", bus_cycles, 2);
        check("bp nSDROE_idle", nSDROE, 1);
        check("bp dout_valid", DOUT_VALID, 1);
        DOUT_READY = 1'b1;
        for (int k = 0; k < 400 && done_cnt == 0; k++) tick();
        for (int k = 0; k < 3; k++) tick();
        check_stream("bp", 24'h000200, 6);
        check("bp done_count", done_cnt, 1);

        // Abort during the read of the third byte.
        clear_logs();
        DOUT_READY = 1'b1;
        pulse_start(24'h000300, 24'h00030F);
        for (int k = 0; k < 200 && !(nSDROE == 1'b0 && bus_cycles == 2); k++) tick();
        check("abort reached_rd3", {nSDROE, 8'(bus_cycles)}, {1'b0, 8'd2});
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        for (int k = 0; k < 50 && BUSY; k++) tick();
        for (int k = 0; k < 4; k++) tick();
        check("abort busy", BUSY, 0);
        check("abort dout_valid", DOUT_VALID, 0);
        check("abort done_count", done_cnt, 0);
        check("abort pops", pop_log.size(), 2);
        check("abort bus_cycles", bus_cycles, 3);
        check("abort oe_low_cycles", last_run, RDC);
        check("abort contention", cont_err, 0);
        run_vec(vecs[3], "after_abort");

        // Asynchronous reset in the middle of a read.
        clear_logs();
        pulse_start(24'h000400, 24'h000410);
        for (int k = 0; k < 50 && nSDROE; k++) tick();
        #1;
        nRESET = 1'b0;
        #1;
        check("arst nSDROE", nSDROE, 1);
        check("arst BUSY", BUSY, 0);
        check("arst SDRMPX", SDRMPX, 0);
        check("arst SDRA_U", SDRA_U, 0);
        check("arst DOUT_VALID", DOUT_VALID, 0);
        tick();
        nRESET = 1'b1;
        tick();
        mpx_prev = 1'b0;
        run_vec(vecs[1], "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
